// File: rtl/output_stationary_psum_bank_if.sv
// Shared output bus between the arbitrated PE cores and the partial-sum bank.
interface output_stationary_psum_bank_if #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [NUM_CORES-1:0]         w_grant;
  logic [ADDR_WIDTH-1:0]        w_burst;
  logic                         w_add_en;
  logic                         w_unload_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic                         w_valid;
  logic signed [DATA_WIDTH-1:0] w_data;
  logic signed [ACC_WIDTH-1:0]  o_data;
  logic                         o_valid;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_err;

  modport master (
    output w_grant, w_burst, w_add_en, w_unload_en, w_addr, w_valid, w_data,
    input  o_data, o_valid, o_busy, o_done, o_err
  );

  modport slave (
    input  w_grant, w_burst, w_add_en, w_unload_en, w_addr, w_valid, w_data,
    output o_data, o_valid, o_busy, o_done, o_err
  );
endinterface

// File: rtl/output_stationary_psum_bank.sv
// Partial-sum bank: saturating accumulate bursts in, destructive unload bursts out.
module output_stationary_psum_bank #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int DEPTH      = 64
) (
  input logic                             w_clock,
  input logic                             w_reset,
  output_stationary_psum_bank_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ADD, UNLOAD, DONE} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                ptr_q, ptr_d;
  logic [AW-1:0]                len_q, len_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic [NUM_CORES-1:0]         gnt_q, gnt_d;
  logic signed [ACC_WIDTH-1:0]  data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         err_q, err_d;
  logic signed [ACC_WIDTH-1:0]  mem_q [DEPTH];
  logic signed [ACC_WIDTH-1:0]  mem_d [DEPTH];

  logic signed [ACC_WIDTH-1:0]  acc_cur;
  logic signed [ACC_WIDTH:0]    sum;
  logic signed [ACC_WIDTH-1:0]  sat_sum;
  logic [AW-1:0]                ptr_next;
  logic                         last_beat;
  logic                         abort;

  // Saturating add of the incoming beat onto the addressed accumulator.
  always_comb begin
    acc_cur = mem_q[ptr_q];
    sum     = {acc_cur[ACC_WIDTH-1], acc_cur}
            + {{(ACC_WIDTH+1-DATA_WIDTH){bus.w_data[DATA_WIDTH-1]}}, bus.w_data};
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      sat_sum = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_sum = sum[ACC_WIDTH-1:0];
    end
  end

  // Next-state, pointer/counter advance and memory update.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    mem_d     = mem_q;
    ptr_next  = (ptr_q == AW'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
    last_beat = (cnt_q == len_q - 1'b1);
    abort     = (bus.w_grant != gnt_q);

    case (state_q)
      IDLE: begin
        if (|bus.w_grant) begin
          if (bus.w_add_en ^ bus.w_unload_en) begin
            ptr_d = bus.w_addr;
            len_d = bus.w_burst;
            gnt_d = bus.w_grant;
            cnt_d = '0;
            if (bus.w_burst == '0) begin
              state_d = DONE;
            end else if (bus.w_add_en) begin
              state_d = ADD;
            end else begin
              state_d = UNLOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.w_valid) begin
          mem_d[ptr_q] = sat_sum;
          ptr_d        = ptr_next;
          cnt_d        = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      UNLOAD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          data_d       = acc_cur;
          valid_d      = 1'b1;
          mem_d[ptr_q] = '0;
          ptr_d        = ptr_next;
          cnt_d        = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and storage registers; reset clears everything.
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  // Output decode; busy and done follow the registered state directly.
  always_comb begin
    bus.o_data  = data_q;
    bus.o_valid = valid_q;
    bus.o_busy  = (state_q == ADD) || (state_q == UNLOAD);
    bus.o_done  = (state_q == DONE);
    bus.o_err   = err_q;
  end
endmodule

// File: tb/tb_output_stationary_psum_bank.sv
// Scoreboard bench for the partial-sum bank (ACC_WIDTH=10 to reach saturation).
module tb_output_stationary_psum_bank;
  localparam int NC    = 4;
  localparam int DW    = 8;
  localparam int ACC   = 10;
  localparam int DEPTH = 64;
  localparam logic [NC-1:0] GNT = 4'b0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_stationary_psum_bank_if #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .ADDR_WIDTH(6)) bus();

  output_stationary_psum_bank #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .DEPTH(DEPTH)) dut (
    .w_clock (clk),
    .w_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model[DEPTH];
  int av[$];
  bit vpat[$];

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    int hi = (1 << (ACC-1)) - 1;
    int lo = -(1 << (ACC-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Compare every unloaded beat with the oldest expected value.
  always @(negedge clk) begin
    int got, e;
    if (!rst && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_valid", int'(bus.o_valid), 0);
      end else begin
        e   = exp_q.pop_front();
        got = $signed(bus.o_data);
        check_eq("unload_data", got, e);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add_xfer(input int a, input int n);
    int k = 0;
    int np;
    int idx;
    @(posedge clk); #1;
    bus.w_grant = GNT; bus.w_add_en = 1'b1;
    bus.w_addr = 6'(a); bus.w_burst = 6'(n);
    @(posedge clk); #1;
    bus.w_add_en = 1'b0;
    np = (vpat.size() == 0) ? n : vpat.size();
    for (int p = 0; p < np && k < n; p++) begin
      if (vpat.size() == 0 || vpat[p]) begin
        bus.w_valid = 1'b1;
        bus.w_data  = 8'(av[k]);
        idx = (a + k) % DEPTH;
        model[idx] = sat(model[idx] + av[k]);
        k++;
      end else begin
        bus.w_valid = 1'b0;
      end
      @(negedge clk);
      if (p == 0) check_eq("add_busy", int'(bus.o_busy), 1);
      @(posedge clk); #1;
    end
    bus.w_valid = 1'b0;
    @(negedge clk);
    check_eq("add_done", int'(bus.o_done), 1);
    check_eq("add_busy_off", int'(bus.o_busy), 0);
    @(posedge clk); #1;
    bus.w_grant = '0;
  endtask

  task automatic unload_xfer(input int a, input int n);
    int idx;
    bit seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      idx = (a + k) % DEPTH;
      exp_q.push_back(model[idx]);
      model[idx] = 0;
    end
    @(posedge clk); #1;
    bus.w_grant = GNT; bus.w_unload_en = 1'b1;
    bus.w_addr = 6'(a); bus.w_burst = 6'(n);
    @(posedge clk); #1;
    bus.w_unload_en = 1'b0;
    for (int c = 0; c < n + 4 && !seen; c++) begin
      @(negedge clk);
      seen = bus.o_done;
    end
    check_eq("unload_done", int'(seen), 1);
    @(posedge clk); #1;
    bus.w_grant = '0;
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1;
    bus.w_grant = '0; bus.w_burst = '0; bus.w_add_en = 1'b0; bus.w_unload_en = 1'b0;
    bus.w_addr = '0; bus.w_valid = 1'b0; bus.w_data = '0;
    do_reset();
    @(negedge clk);
    check_eq("rst_valid", int'(bus.o_valid), 0);
    check_eq("rst_busy", int'(bus.o_busy), 0);
    check_eq("rst_done", int'(bus.o_done), 0);
    check_eq("rst_err", int'(bus.o_err), 0);
    check_eq("rst_data", int'(bus.o_data), 0);

    // Fresh bank unloads zeros.
    unload_xfer(0, 4);

    // Accumulate twice then unload, then unload again.
    vpat.delete();
    av = {10, -3, 7};
    add_xfer(5, 3);
    add_xfer(5, 3);
    unload_xfer(5, 3);
    @(negedge clk);
    check_eq("hold_valid", int'(bus.o_valid), 0);
    check_eq("hold_data", int'($signed(bus.o_data)), 14);
    unload_xfer(5, 3);

    // Positive and negative saturation.
    av = {127};
    repeat (5) add_xfer(0, 1);
    unload_xfer(0, 1);
    av = {-128};
    repeat (5) add_xfer(0, 1);
    unload_xfer(0, 1);

    // Address wrap-around.
    av = {1, 2, 3, 4};
    add_xfer(62, 4);
    unload_xfer(62, 2);
    unload_xfer(0, 3);

    // Stalled beats.
    av = {1, 2, 3, 4, 5, 6};
    vpat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    add_xfer(20, 6);
    vpat.delete();
    unload_xfer(20, 7);

    // Grant dropped after two of five beats.
    @(posedge clk); #1;
    bus.w_grant = GNT; bus.w_add_en = 1'b1; bus.w_addr = 6'd30; bus.w_burst = 6'd5;
    @(posedge clk); #1;
    bus.w_add_en = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 8'sd11; model[30] = 11;
    @(posedge clk); #1;
    bus.w_data = 8'sd22; model[31] = 22;
    @(posedge clk); #1;
    bus.w_grant = '0; bus.w_data = 8'sd99;
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_err", int'(bus.o_err), 1);
    check_eq("abort_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    check_eq("abort_err_pulse", int'(bus.o_err), 0);
    unload_xfer(30, 5);

    // Both enables at start.
    @(posedge clk); #1;
    bus.w_grant = GNT; bus.w_add_en = 1'b1; bus.w_unload_en = 1'b1;
    bus.w_addr = 6'd40; bus.w_burst = 6'd3; bus.w_valid = 1'b1; bus.w_data = 8'sd5;
    @(posedge clk); #1;
    bus.w_grant = '0; bus.w_add_en = 1'b0; bus.w_unload_en = 1'b0; bus.w_valid = 1'b0;
    @(negedge clk);
    check_eq("both_en_err", int'(bus.o_err), 1);
    check_eq("both_en_busy", int'(bus.o_busy), 0);
    unload_xfer(40, 3);

    // Reset in the middle of an unload.
    av = {1, 2, 3, 4};
    add_xfer(50, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(model[50 + k]);
    @(posedge clk); #1;
    bus.w_grant = GNT; bus.w_unload_en = 1'b1; bus.w_addr = 6'd50; bus.w_burst = 6'd4;
    @(posedge clk); #1;
    bus.w_unload_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); seen |= bus.o_done;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen |= bus.o_done;
    end
    check_eq("rst_mid_no_done", int'(seen), 0);
    check_eq("rst_mid_busy", int'(bus.o_busy), 0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    bus.w_grant = '0;
    unload_xfer(0, 63);
    unload_xfer(63, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
